// File: rtl/lb_arb_pkg.sv
// Shared constants for the 68040 local-bus arbiter: FSM encodings, owner codes
// and the default grant timeout.
package lb_arb_pkg;

    localparam logic [2:0] CPU_GRANT   = 3'b000;
    localparam logic [2:0] CPU_RELEASE = 3'b001;
    localparam logic [2:0] GRANT_ALT   = 3'b010;
    localparam logic [2:0] ALT_BUSY    = 3'b011;
    localparam logic [2:0] DEAD        = 3'b100;

    localparam logic [2:0] OWNER_CPU       = 3'd0;
    localparam int         GNT_TIMEOUT_DEF = 15;

    // Alternate-master index; wide enough for the maximum of four masters.
    localparam int IDX_W = 2;
    typedef logic [IDX_W-1:0] alt_idx_t;

    function automatic logic [2:0] owner_code(alt_idx_t idx);
        return 3'(idx) + 3'd1;
    endfunction

endpackage

// File: rtl/lb_bus_arbiter_if.sv
// Request/grant/busy signal bundle between the local-bus arbiter (master
// modport) and the bus masters plus buffer/sizing logic (slave modport).
interface lb_bus_arbiter_if #(
    parameter int NUM_ALT = 2
);
    logic               nBR_CPU;
    logic               nBG_CPU;
    logic [NUM_ALT-1:0] nBR_ALT;
    logic [NUM_ALT-1:0] nBG_ALT;
    logic               nBB;
    logic               nLOCK;
    logic [2:0]         OWNER;
    logic               CPUBUSEN;

    modport master (
        input  nBR_CPU, nBR_ALT, nBB, nLOCK,
        output nBG_CPU, nBG_ALT, OWNER, CPUBUSEN
    );

    modport slave (
        output nBR_CPU, nBR_ALT, nBB, nLOCK,
        input  nBG_CPU, nBG_ALT, OWNER, CPUBUSEN
    );
endinterface

// File: rtl/lb_rr_pick.sv
// Combinational round-robin selector: first active request at or above rr,
// wrapping around the N request lines.
module lb_rr_pick
    import lb_arb_pkg::*;
#(
    parameter int N = 2
) (
    input  logic [N-1:0] req,
    input  alt_idx_t     rr,
    output logic         valid,
    output alt_idx_t     idx
);

    // Walk from the farthest offset down so the nearest request overwrites.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        valid = 1'b0;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[(int'(rr) + i) % N]) begin
                valid = 1'b1;
                idx   = alt_idx_t'((int'(rr) + i) % N);
            end
        end
    end

endmodule

// File: rtl/lb_bus_arbiter.sv
// 68040 local-bus arbiter: CPU parked by default, round-robin among alternate
// masters. Optional locked-sequence protection with macro ARB_LOCK_EN.
module lb_bus_arbiter
    import lb_arb_pkg::*;
#(
    parameter int NUM_ALT     = 2,
    parameter int GNT_TIMEOUT = GNT_TIMEOUT_DEF
) (
    input logic               BCLK,
    input logic               nRESET,
    lb_bus_arbiter_if.master  bus
);

    localparam logic [7:0] TMO      = 8'(GNT_TIMEOUT);
    localparam alt_idx_t   LAST_ALT = alt_idx_t'(NUM_ALT - 1);

    logic [2:0]   state, state_nxt;
    alt_idx_t     sel, sel_nxt;
    alt_idx_t     rr, rr_nxt;
    logic [7:0]   cnt, cnt_nxt;
    logic         bb_seen, bb_seen_nxt;
    logic         pick_valid;
    alt_idx_t     pick_idx;
    logic         lock_hold;
    logic         granted_nxt;
    logic [NUM_ALT-1:0] gnt_n_nxt;

    wire [NUM_ALT-1:0] alt_req  = ~bus.nBR_ALT;
    wire [3:0]         alt_req4 = 4'(alt_req);
    wire               bb_busy  = ~bus.nBB;

    lb_rr_pick #(.N(NUM_ALT)) u_pick (
        .req   (alt_req),
        .rr    (rr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

`ifdef ARB_LOCK_EN
    // The tail of a locked sequence may still be on the bus for one cycle.
    logic lock_prev;
    always_ff @(posedge BCLK or negedge nRESET) begin
        if (!nRESET) lock_prev <= 1'b0;
        else         lock_prev <= ~bus.nLOCK;
    end
    assign lock_hold = ~bus.nLOCK | (bb_busy & lock_prev);
    wire unused_ok = bus.nBR_CPU;
`else
    assign lock_hold = 1'b0;
    wire unused_ok = bus.nBR_CPU ^ bus.nLOCK;
`endif

    always_comb begin
        state_nxt   = state;
        sel_nxt     = sel;
        rr_nxt      = rr;
        cnt_nxt     = cnt;
        bb_seen_nxt = 1'b0;
        case (state)
            CPU_GRANT:
                if (pick_valid && !lock_hold) state_nxt = CPU_RELEASE;
            CPU_RELEASE:
                if (!pick_valid) begin
                    state_nxt = CPU_GRANT;
                end else if (!bb_busy) begin
                    if (bb_seen) begin
                        state_nxt = GRANT_ALT;
                        sel_nxt   = pick_idx;
                        cnt_nxt   = '0;
                    end else begin
                        bb_seen_nxt = 1'b1;
                    end
                end
            GRANT_ALT: begin
                cnt_nxt = cnt + 8'd1;
                if (bb_busy) begin
                    state_nxt = ALT_BUSY;
                    cnt_nxt   = '0;
                end else if (!alt_req4[sel] || cnt_nxt >= TMO) begin
                    state_nxt = DEAD;
                    rr_nxt    = (sel == LAST_ALT) ? '0 : sel + alt_idx_t'(1);
                end
            end
            ALT_BUSY:
                if (!bb_busy) begin
                    state_nxt = DEAD;
                    rr_nxt    = (sel == LAST_ALT) ? '0 : sel + alt_idx_t'(1);
                end
            DEAD:
                if (!bb_busy) begin
                    if (pick_valid) begin
                        state_nxt = GRANT_ALT;
                        sel_nxt   = pick_idx;
                        cnt_nxt   = '0;
                    end else begin
                        state_nxt = CPU_GRANT;
                    end
                end
            default: state_nxt = CPU_GRANT;
        endcase
    end

    // Grants are decoded from the next state so they leave the flops directly.
    assign granted_nxt = (state_nxt == GRANT_ALT) || (state_nxt == ALT_BUSY);
    always_comb begin
        gnt_n_nxt = '1;
        for (int i = 0; i < NUM_ALT; i++)
            if (granted_nxt && sel_nxt == alt_idx_t'(i)) gnt_n_nxt[i] = 1'b0;
    end

    always_ff @(posedge BCLK or negedge nRESET) begin
        if (!nRESET) begin
            state        <= CPU_GRANT;
            sel          <= '0;
            rr           <= '0;
            cnt          <= '0;
            bb_seen      <= 1'b0;
            bus.nBG_CPU  <= 1'b0;
            bus.nBG_ALT  <= '1;
            bus.OWNER    <= OWNER_CPU;
            bus.CPUBUSEN <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop
            // samples the pre-edge values, independent of statement order.
            state        <= state_nxt;
            sel          <= sel_nxt;
            rr           <= rr_nxt;
            cnt          <= cnt_nxt;
            bb_seen      <= bb_seen_nxt;
            bus.nBG_CPU  <= (state_nxt != CPU_GRANT);
            bus.nBG_ALT  <= gnt_n_nxt;
            bus.OWNER    <= granted_nxt ? owner_code(sel_nxt) : OWNER_CPU;
            bus.CPUBUSEN <= ~bus.nBG_CPU | (bus.CPUBUSEN & bb_busy);
        end
    end

endmodule

// File: tb/tb_lb_bus_arbiter.sv
// Directed bench for lb_bus_arbiter (NUM_ALT=2, GNT_TIMEOUT=15); expectations
// follow ARB_LOCK_EN when the macro is defined for the build.
module tb_lb_bus_arbiter;

    logic BCLK;
    logic nRESET;
    int   n_tests = 0;
    int   n_fail  = 0;

    lb_bus_arbiter_if #(.NUM_ALT(2)) bus ();

    lb_bus_arbiter #(.NUM_ALT(2), .GNT_TIMEOUT(15)) dut (
        .BCLK   (BCLK),
        .nRESET (nRESET),
        .bus    (bus)
    );

    initial BCLK = 1'b0;
    always #5 BCLK = ~BCLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic chk_bus(input string tag, input logic cpu, input logic [1:0] alt,
                           input logic [2:0] own);
        check({tag, ".nBG_CPU"}, 32'(bus.nBG_CPU), 32'(cpu));
        check({tag, ".nBG_ALT"}, 32'(bus.nBG_ALT), 32'(alt));
        check({tag, ".OWNER"},   32'(bus.OWNER),   32'(own));
    endtask

    // Advance n rising edges; inputs and checks happen 1 ns after the edge.
    task automatic step(input int n);
        repeat (n) @(posedge BCLK);
        #1;
    endtask

    // From the grant edge: master drives nBB low one cycle, releases, DEAD follows.
    task automatic tenure(input string tag, input logic [1:0] gnt, input logic [2:0] own);
        chk_bus({tag, ".grant"}, 1'b1, gnt, own);
        bus.nBB = 1'b0;
        step(1);
        chk_bus({tag, ".busy"}, 1'b1, gnt, own);
        bus.nBB = 1'b1;
        step(1);
        chk_bus({tag, ".dead"}, 1'b1, 2'b11, 3'd0);
    endtask

    initial begin
        nRESET      = 1'b0;
        bus.nBR_CPU = 1'b1;
        bus.nBR_ALT = 2'b11;
        bus.nBB     = 1'b1;
        bus.nLOCK   = 1'b1;

        // Reset values, then CPU buffers enabled one edge after release.
        step(2);
        chk_bus("reset", 1'b0, 2'b11, 3'd0);
        check("reset.CPUBUSEN", 32'(bus.CPUBUSEN), 32'd0);
        nRESET = 1'b1;
        step(1);
        chk_bus("parked", 1'b0, 2'b11, 3'd0);
        check("parked.CPUBUSEN", 32'(bus.CPUBUSEN), 32'd1);

        // Idle CPU, alt 0 requests: release, two nBB-high edges, grant.
        bus.nBR_ALT = 2'b10;
        step(1);
        chk_bus("a0.release", 1'b1, 2'b11, 3'd0);
        step(1);
        chk_bus("a0.wait", 1'b1, 2'b11, 3'd0);
        check("a0.CPUBUSEN_off", 32'(bus.CPUBUSEN), 32'd0);
        step(1);
        bus.nBR_ALT = 2'b11;
        tenure("a0", 2'b10, 3'd1);
        step(1);
        chk_bus("a0.back_cpu", 1'b0, 2'b11, 3'd0);
        step(1);
        check("a0.CPUBUSEN_on", 32'(bus.CPUBUSEN), 32'd1);

        // CPU transfer in flight for 6 cycles when alt 1 requests.
        bus.nBB     = 1'b0;
        bus.nBR_ALT = 2'b01;
        step(1);
        chk_bus("inflight.release", 1'b1, 2'b11, 3'd0);
        check("inflight.CPUBUSEN", 32'(bus.CPUBUSEN), 32'd1);
        for (int i = 0; i < 5; i++) begin
            step(1);
            check("inflight.hold_en", 32'(bus.CPUBUSEN), 32'd1);
            check("inflight.no_gnt", 32'(bus.nBG_ALT), 32'h3);
        end
        bus.nBB = 1'b1;
        step(1);
        chk_bus("inflight.bb1", 1'b1, 2'b11, 3'd0);
        check("inflight.CPUBUSEN_off", 32'(bus.CPUBUSEN), 32'd0);
        step(1);
        bus.nBR_ALT = 2'b11;
        tenure("a1", 2'b01, 3'd2);
        step(1);
        chk_bus("a1.back_cpu", 1'b0, 2'b11, 3'd0);

        // Both alternates requesting: 0,1,0,1 with a DEAD cycle between.
        bus.nBR_ALT = 2'b00;
        step(3);
        tenure("rr0", 2'b10, 3'd1);
        step(1);
        tenure("rr1", 2'b01, 3'd2);
        step(1);
        tenure("rr2", 2'b10, 3'd1);
        step(1);
        tenure("rr3", 2'b01, 3'd2);
        bus.nBR_ALT = 2'b11;
        step(1);
        chk_bus("rr.back_cpu", 1'b0, 2'b11, 3'd0);

        // Alt 0 granted but never drives nBB: revoked after 15 cycles, alt 1 next.
        bus.nBR_ALT = 2'b00;
        step(3);
        chk_bus("tmo.grant", 1'b1, 2'b10, 3'd1);
        step(14);
        chk_bus("tmo.still", 1'b1, 2'b10, 3'd1);
        step(1);
        chk_bus("tmo.revoked", 1'b1, 2'b11, 3'd0);
        step(1);
        bus.nBR_ALT = 2'b11;
        tenure("tmo.a1", 2'b01, 3'd2);
        step(1);
        chk_bus("tmo.back_cpu", 1'b0, 2'b11, 3'd0);

        // Locked CPU sequence with an alt request pending.
        bus.nLOCK   = 1'b0;
        bus.nBB     = 1'b0;
        bus.nBR_ALT = 2'b10;
        step(1);
`ifdef ARB_LOCK_EN
        chk_bus("lock.hold1", 1'b0, 2'b11, 3'd0);
        step(2);
        chk_bus("lock.hold3", 1'b0, 2'b11, 3'd0);
        bus.nLOCK = 1'b1;
        bus.nBB   = 1'b1;
        step(1);
        chk_bus("lock.released", 1'b1, 2'b11, 3'd0);
`else
        chk_bus("nolock.release", 1'b1, 2'b11, 3'd0);
`endif

        // Reset mid-tenure returns grants at once.
        nRESET      = 1'b0;
        bus.nLOCK   = 1'b1;
        bus.nBB     = 1'b1;
        bus.nBR_ALT = 2'b11;
        #3;
        nRESET = 1'b1;
        bus.nBR_ALT = 2'b10;
        step(3);
        chk_bus("midrst.grant", 1'b1, 2'b10, 3'd1);
        bus.nBB = 1'b0;
        step(1);
        nRESET = 1'b0;
        #1;
        chk_bus("midrst.reset", 1'b0, 2'b11, 3'd0);
        check("midrst.CPUBUSEN", 32'(bus.CPUBUSEN), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
